cordic_vec_sched: RTL and testbench

- Sequencer and arbiter that shares one iterative vectoring CORDIC datapath among NREQ requesters.
- Datapath is the vectoring pre-processor (quadrant fold into x>=0, registered x0/y0/z0) followed by an iterative micro-rotation core.
- Block grants one request at a time round-robin, drives pre-processor ce/load, steps the core through N_ITER iterations, then presents a tagged result with valid/ready backpressure.

---
 rtl/cordic_pkg.sv | 42 ++++
 rtl/cordic_rr_arb.sv | 46 ++++
 rtl/cordic_vec_sched.sv | 150 +++++++++++++++
 tb/tb_cordic_vec_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the vectoring CORDIC scheduler family.
package cordic_pkg;

    // Widest requester vector the round-robin helper can search.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } vec_state_t;

    // Next round-robin winner: the first set bit of valid, searching
    // last+1, last+2, ... modulo nreq. Returns -1 when nothing is valid.
    function automatic int rr_next(input logic [RR_MAX-1:0] valid,
                                   input int                last,
                                   input int                nreq);
        int win;
        int cand;
        win = -1;
        for (int k = 1; k <= RR_MAX; k++) begin
            cand = last + k;
            if (cand >= nreq) begin
                cand = cand - nreq;
            end else begin
                cand = cand;
            end
            if ((win < 0) && (k <= nreq) && (cand >= 0) && (cand < RR_MAX)) begin
                if (valid[cand[RR_IDX_W-1:0]]) begin
                    win = cand;
                end else begin
                    win = win;
                end
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: combinational winner select, last-grant register
// updated only when a grant is actually issued.
module cordic_rr_arb
    import cordic_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] win_id
);

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]   rr_last_r;
    logic [RR_MAX-1:0] valid_pad_s;
    int                win_s;

    // Pick the next requester after the last grant; grant only when enabled.
    always_comb begin
        valid_pad_s             = '0;
        valid_pad_s[NREQ-1:0]   = req_valid;
        win_s                   = rr_next(valid_pad_s, int'(rr_last_r), NREQ);
        if (en && (win_s >= 0)) begin
            win_id = ID_W'(win_s);
            grant  = ONE_HOT0 << win_id;
        end else begin
            win_id = '0;
            grant  = '0;
        end
    end

    // Remember the last granted requester; requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= ID_W'(NREQ - 1);
        end else if (|grant) begin
            rr_last_r <= win_id;
        end
    end

endmodule

// File: rtl/cordic_vec_sched.sv
// Sequencer/arbiter sharing one iterative vectoring CORDIC datapath among
// NREQ requesters: grant, load pre-processor, step N_ITER iterations, then
// hold a tagged result until downstream accepts it.
module cordic_vec_sched
    import cordic_pkg::*;
#(
    parameter  int XY_W   = 16,
    parameter  int N_ITER = 16,
    parameter  int NREQ   = 2,
    localparam int ID_W   = $clog2(NREQ),
    localparam int IT_W   = $clog2(N_ITER)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XY_W-1:0] req_x,
    input  logic [NREQ*XY_W-1:0] req_y,
    output logic                 pp_ce,
    output logic                 pp_load,
    output logic [XY_W-1:0]      pp_x_in,
    output logic [XY_W-1:0]      pp_y_in,
    output logic                 core_ce,
    output logic                 core_first,
    output logic [IT_W-1:0]      core_iter,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    vec_state_t      state_r;
    logic [IT_W-1:0] iter_cnt_r;
    logic [ID_W-1:0] cur_id_r;
    logic            core_ce_r;
    logic            core_first_r;
    logic            res_valid_r;
    logic            busy_r;

    logic            arb_en_s;
    logic [NREQ-1:0] grant_s;
    logic [ID_W-1:0] win_id_s;
    logic            accept_s;
    logic [ID_W-1:0] sel_s;
    logic [XY_W-1:0] x_arr_s [NREQ];
    logic [XY_W-1:0] y_arr_s [NREQ];

    // Arbitration only in IDLE; flush suppresses any grant that cycle.
    assign arb_en_s = (state_r == IDLE) && !flush;

    cordic_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en_s),
        .req_valid (req_valid),
        .grant     (grant_s),
        .win_id    (win_id_s)
    );

    assign accept_s  = |grant_s;
    assign req_ready = grant_s;
    assign pp_ce     = accept_s;
    assign pp_load   = accept_s;

    // Unpack flattened operands and steer the winner (on accept) or the current owner.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            x_arr_s[i] = req_x[i*XY_W +: XY_W];
            y_arr_s[i] = req_y[i*XY_W +: XY_W];
        end
        if (accept_s) begin
            sel_s = win_id_s;
        end else begin
            sel_s = cur_id_r;
        end
        pp_x_in = x_arr_s[sel_s];
        pp_y_in = y_arr_s[sel_s];
    end

    // Operation sequencer: IDLE -> ITER (N_ITER steps) -> DONE -> IDLE, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            iter_cnt_r   <= '0;
            cur_id_r     <= '0;
            core_ce_r    <= 1'b0;
            core_first_r <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else if (flush) begin
            state_r      <= IDLE;
            iter_cnt_r   <= '0;
            core_ce_r    <= 1'b0;
            core_first_r <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r      <= ITER;
                        iter_cnt_r   <= '0;
                        cur_id_r     <= win_id_s;
                        core_ce_r    <= 1'b1;
                        core_first_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end
                end
                ITER: begin
                    core_first_r <= 1'b0;
                    if (iter_cnt_r == IT_W'(N_ITER - 1)) begin
                        state_r     <= DONE;
                        iter_cnt_r  <= '0;
                        core_ce_r   <= 1'b0;
                        res_valid_r <= 1'b1;
                    end else begin
                        iter_cnt_r <= iter_cnt_r + IT_W'(1);
                    end
                end
                DONE: begin
                    // core_ce stays low so the core outputs hold the result.
                    if (res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    iter_cnt_r   <= '0;
                    core_ce_r    <= 1'b0;
                    core_first_r <= 1'b0;
                    res_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign core_ce    = core_ce_r;
    assign core_first = core_first_r;
    assign core_iter  = iter_cnt_r;
    assign res_valid  = res_valid_r;
    assign res_id     = cur_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_cordic_vec_sched.sv
// Self-checking bench for cordic_vec_sched: arbitration table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_cordic_vec_sched;

    localparam int XY_W   = 16;
    localparam int N_ITER = 16;
    localparam int NREQ   = 2;
    localparam int ID_W   = 1;
    localparam int IT_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XY_W-1:0] req_x;
    logic [NREQ*XY_W-1:0] req_y;
    logic                 pp_ce;
    logic                 pp_load;
    logic [XY_W-1:0]      pp_x_in;
    logic [XY_W-1:0]      pp_y_in;
    logic                 core_ce;
    logic                 core_first;
    logic [IT_W-1:0]      core_iter;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [6:0] ctl_s;
    assign ctl_s = {req_ready, pp_ce, pp_load, core_ce, res_valid, busy};

    cordic_vec_sched #(
        .XY_W   (XY_W),
        .N_ITER (N_ITER),
        .NREQ   (NREQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .pp_ce      (pp_ce),
        .pp_load    (pp_load),
        .pp_x_in    (pp_x_in),
        .pp_y_in    (pp_y_in),
        .core_ce    (core_ce),
        .core_first (core_first),
        .core_iter  (core_iter),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] mk(input logic [1:0] rr, input logic pp, input logic cce,
                                      input logic rv, input logic b);
        return {rr, pp, pp, cce, rv, b};
    endfunction

    function automatic logic [15:0] opnd(input logic [31:0] v, input int i);
        return (i == 1) ? v[31:16] : v[15:0];
    endfunction

    // Reference round robin: first valid requester after 'last', modulo NREQ.
    function automatic int model_winner(input logic [1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Check one full operation starting in its first ITER cycle, with bp stall cycles in DONE.
    task automatic do_op(input int id, input int bp);
        for (int k = 0; k < N_ITER; k++) begin
            @(negedge clk);
            chk("iter_ctl", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1)));
            chk("iter_idx", 32'({core_first, core_iter}), 32'({(k == 0), 4'(k)}));
            adv();
        end
        res_ready = (bp == 0);
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            chk("done_hold", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
            chk("done_hold_id", 32'(res_id), 32'(id));
            adv();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("done_ctl", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
        chk("done_id", 32'(res_id), 32'(id));
        adv();
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_ready;
        int         bp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   prev_acc;
        int   prev_bp;
        int   wid;
        int   w;
        logic acc;
        logic [15:0] x0, x1, y0, y1;
        logic [1:0]  exp_rr;
        int   m_busy, m_t, m_id, m_last;

        tbl[0] = '{2'b01, 2'b01, 0};   // single request, x=3 y=4
        tbl[1] = '{2'b11, 2'b10, 0};
        tbl[2] = '{2'b11, 2'b01, 0};
        tbl[3] = '{2'b11, 2'b10, 0};
        tbl[4] = '{2'b11, 2'b01, 0};
        tbl[5] = '{2'b10, 2'b10, 10};  // backpressure
        tbl[6] = '{2'b10, 2'b10, 0};
        tbl[7] = '{2'b00, 2'b00, 0};
        tbl[8] = '{2'b01, 2'b01, 0};
        tbl[9] = '{2'b11, 2'b10, 0};

        rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; res_ready = 1'b1;
        req_x = 32'd0; req_y = 32'd0;
        #2;
        chk("reset_ctl", 32'(ctl_s), 32'd0);
        chk("reset_core", 32'({core_first, core_iter, res_id}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        adv();

        // Table-driven arbitration and timing.
        prev_acc = -1;
        prev_bp  = 0;
        for (int i = 0; i < 10; i++) begin
            x0 = (i == 0) ? 16'd3 : 16'(i * 37 + 1);
            y0 = (i == 0) ? 16'd4 : 16'(i * 11 + 5);
            x1 = 16'(16'h8000 + i * 3);
            y1 = 16'(16'h7000 - i * 9);
            req_x = {x1, x0};
            req_y = {y1, y0};
            req_valid = tbl[i].valid;
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("arb_ready", 32'(req_ready), 32'(tbl[i].exp_ready));
            acc = (tbl[i].exp_ready != 2'b00);
            chk("arb_pp", 32'({pp_ce, pp_load}), 32'({acc, acc}));
            wid = tbl[i].exp_ready[1] ? 1 : 0;
            if (acc) begin
                chk("pp_x_in", 32'(pp_x_in), 32'(wid ? x1 : x0));
                chk("pp_y_in", 32'(pp_y_in), 32'(wid ? y1 : y0));
                if (prev_acc >= 0 && prev_bp == 0) begin
                    chk("rr_period", 32'(cyc - prev_acc), 32'(N_ITER + 2));
                end
                prev_acc = cyc;
                prev_bp  = tbl[i].bp;
            end else begin
                prev_acc = -1;
            end
            adv();
            if (acc) do_op(wid, tbl[i].bp);
        end
        // last grant was requester 1

        // Flush at iteration 5.
        req_valid = 2'b01;
        @(negedge clk);
        chk("fl5_accept", 32'(req_ready), 32'd1);
        adv();
        req_valid = 2'b00;
        for (int k = 0; k < 5; k++) adv();
        flush = 1'b1;
        @(negedge clk);
        chk("fl5_iter", 32'({core_ce, core_iter}), 32'({1'b1, 4'd5}));
        adv();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl5_idle", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0)));
            adv();
        end
        req_valid = 2'b10;   // last grant 0 -> requester 1
        @(negedge clk);
        chk("fl5_regrant", 32'(req_ready), 32'd2);
        adv();
        do_op(1, 0);

        // Flush coincident with requests in IDLE: no accept, fairness unchanged.
        req_valid = 2'b11;
        flush = 1'b1;
        @(negedge clk);
        chk("flidle_ctl", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0)));
        adv();
        flush = 1'b0;
        @(negedge clk);
        chk("flidle_busy", 32'(busy), 32'd0);
        chk("flidle_regrant", 32'(req_ready), 32'd1);
        adv();
        do_op(0, 0);

        // Flush in DONE together with res_ready: single return to IDLE.
        req_valid = 2'b10;
        @(negedge clk);
        chk("fldone_accept", 32'(req_ready), 32'd2);
        adv();
        req_valid = 2'b00;
        for (int k = 0; k < N_ITER; k++) adv();
        flush = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("fldone_done", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
        adv();
        flush = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        chk("fldone_next", 32'(ctl_s), 32'(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0)));
        adv();

        // Async reset mid-ITER.
        for (int k = 0; k < 3; k++) adv();
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rst_mid_ctl", 32'(ctl_s), 32'd0);
        chk("rst_mid_core", 32'({core_first, core_iter, res_id}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_regrant", 32'(req_ready), 32'd1);
        adv();
        do_op(0, 0);

        // Randomized traffic against a transaction-level model.
        m_busy = 0; m_t = 0; m_id = 0; m_last = 0;
        for (int c = 0; c < 600; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_x     = $urandom;
            req_y     = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            if (m_busy == 0) begin
                w = model_winner(req_valid, m_last);
                exp_rr = (flush || w < 0) ? 2'b00 : (2'b01 << w);
                chk("rnd_idle", 32'(ctl_s), 32'(mk(exp_rr, (exp_rr != 2'b00), 1'b0, 1'b0, 1'b0)));
                if (exp_rr != 2'b00) begin
                    chk("rnd_pp_x", 32'(pp_x_in), 32'(opnd(req_x, w)));
                    chk("rnd_pp_y", 32'(pp_y_in), 32'(opnd(req_y, w)));
                    m_busy = 1; m_t = 0; m_id = w; m_last = w;
                end else begin
                    chk("rnd_hold_x", 32'(pp_x_in), 32'(opnd(req_x, m_last)));
                end
            end else begin
                m_t++;
                chk("rnd_own_x", 32'(pp_x_in), 32'(opnd(req_x, m_id)));
                if (m_t <= N_ITER) begin
                    chk("rnd_iter", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1)));
                    chk("rnd_iter_idx", 32'({core_first, core_iter}), 32'({(m_t == 1), 4'(m_t - 1)}));
                end else begin
                    chk("rnd_done", 32'(ctl_s), 32'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
                    chk("rnd_done_id", 32'(res_id), 32'(m_id));
                    if (res_ready) m_busy = 0;
                end
                if (flush) m_busy = 0;
            end
            adv();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
